// File: rtl/cayde_pkg.sv
// Shared types for the cayde decode stage: opcodes, ALU operation codes and the
// control bundle handed from decode to execute.
package cayde_pkg;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011
    } opcode_e;

    typedef enum logic [6:0] {
        ALU_ADD    = 7'd0,
        ALU_SUB    = 7'd1,
        ALU_XOR    = 7'd2,
        ALU_AND    = 7'd3,
        ALU_OR     = 7'd4,
        ALU_SLL    = 7'd5,
        ALU_SLT    = 7'd6,
        ALU_SLTU   = 7'd7,
        ALU_SRL    = 7'd8,
        ALU_SRA    = 7'd9,
        ALU_MUL    = 7'd10,
        ALU_MULH   = 7'd11,
        ALU_MULHSU = 7'd12,
        ALU_MULHU  = 7'd13,
        ALU_DIV    = 7'd14,
        ALU_DIVU   = 7'd15,
        ALU_REM    = 7'd16,
        ALU_REMU   = 7'd17
    } alu_op_e;

    // Immediate travels beside the bundle so its width can follow XLEN.
    typedef struct packed {
        alu_op_e    alu_op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       use_imm;
        logic       illegal;
    } decode_bundle_t;

    localparam decode_bundle_t BUNDLE_RESET = '{
        alu_op: ALU_ADD, rs1: '0, rs2: '0, rd: '0, use_imm: 1'b0, illegal: 1'b0
    };

    function automatic alu_op_e m_op(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/cayde_decode_comb.sv
// Combinational OP / OP-IMM (+ optional M) decoder: instruction word to control
// bundle and XLEN-wide immediate.
module cayde_decode_comb
    import cayde_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          EN_MEXT = 1'b1
) (
    input  logic [31:0]     instr,
    output decode_bundle_t  bundle,
    output logic [XLEN-1:0] imm
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    logic [6:0]         funct7;
    logic [2:0]         funct3;
    logic [SHAMT_W-1:0] shamt;
    logic               sh_hi_zero;
    logic               sh_hi_sra;

    always_comb begin
        funct7     = instr[31:25];
        funct3     = instr[14:12];
        shamt      = instr[20 +: SHAMT_W];
        sh_hi_zero = (instr[31:20+SHAMT_W] == '0);
        sh_hi_sra  = (instr[31:26] == 6'b010000) && ((XLEN == 64) || !instr[25]);

        bundle.alu_op  = ALU_ADD;
        bundle.rs1     = instr[19:15];
        bundle.rs2     = instr[24:20];
        bundle.rd      = instr[11:7];
        bundle.use_imm = 1'b0;
        bundle.illegal = 1'b0;
        imm            = '0;

        case (instr[6:0])
            OPC_OP: begin
                case ({funct7, funct3})
                    10'b0000000_000: bundle.alu_op = ALU_ADD;
                    10'b0100000_000: bundle.alu_op = ALU_SUB;
                    10'b0000000_100: bundle.alu_op = ALU_XOR;
                    10'b0000000_111: bundle.alu_op = ALU_AND;
                    10'b0000000_110: bundle.alu_op = ALU_OR;
                    10'b0000000_001: bundle.alu_op = ALU_SLL;
                    10'b0000000_010: bundle.alu_op = ALU_SLT;
                    10'b0000000_011: bundle.alu_op = ALU_SLTU;
                    10'b0000000_101: bundle.alu_op = ALU_SRL;
                    10'b0100000_101: bundle.alu_op = ALU_SRA;
                    default: begin
                        if (EN_MEXT && funct7 == 7'b0000001) bundle.alu_op = m_op(funct3);
                        else                                 bundle.illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP_IMM: begin
                bundle.use_imm = 1'b1;
                bundle.rs2     = '0;
                imm            = XLEN'($signed(instr[31:20]));
                case (funct3)
                    3'b000: bundle.alu_op = ALU_ADD;
                    3'b010: bundle.alu_op = ALU_SLT;
                    3'b011: bundle.alu_op = ALU_SLTU;
                    3'b100: bundle.alu_op = ALU_XOR;
                    3'b110: bundle.alu_op = ALU_OR;
                    3'b111: bundle.alu_op = ALU_AND;
                    3'b001: begin
                        bundle.alu_op  = ALU_SLL;
                        bundle.illegal = !sh_hi_zero;
                        imm            = XLEN'(shamt);
                    end
                    default: begin
                        imm = XLEN'(shamt);
                        if (sh_hi_zero)     bundle.alu_op  = ALU_SRL;
                        else if (sh_hi_sra) bundle.alu_op  = ALU_SRA;
                        else                bundle.illegal = 1'b1;
                    end
                endcase
            end
            default: bundle.illegal = 1'b1;
        endcase

        if (bundle.illegal) begin
            bundle.alu_op  = ALU_ADD;
            bundle.rd      = '0;
            bundle.use_imm = 1'b0;
            imm            = '0;
        end
    end

endmodule

// File: rtl/cayde_decode_stage.sv
// Registered decode stage: combinational decode into a 2-entry skid buffer
// (output register + skid register) with a saturating illegal-instruction counter.
module cayde_decode_stage
    import cayde_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          EN_MEXT  = 1'b1,
    parameter int unsigned ALU_OP_W = 7,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [4:0]          rd,
    output logic [XLEN-1:0]     imm,
    output logic                use_imm,
    output logic                illegal,
    output logic [CNT_W-1:0]    illegal_cnt
);

    decode_bundle_t  dec_b, out_b, skid_b;
    logic [XLEN-1:0] dec_imm, out_imm, skid_imm;
    logic            out_v, skid_v;
    logic            accept;

    cayde_decode_comb #(
        .XLEN    (XLEN),
        .EN_MEXT (EN_MEXT)
    ) u_dec (
        .instr  (instr_in),
        .bundle (dec_b),
        .imm    (dec_imm)
    );

    assign accept = in_valid && !skid_v;

    // The skid entry only ever fills while the output register is full and
    // stalled, so draining it never coincides with an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v       <= 1'b0;
            skid_v      <= 1'b0;
            out_b       <= BUNDLE_RESET;
            skid_b      <= BUNDLE_RESET;
            out_imm     <= '0;
            skid_imm    <= '0;
            illegal_cnt <= '0;
        end else begin
            if (!out_v || out_ready) begin
                if (skid_v) begin
                    out_b   <= skid_b;
                    out_imm <= skid_imm;
                    out_v   <= 1'b1;
                    skid_v  <= 1'b0;
                end else if (accept) begin
                    out_b   <= dec_b;
                    out_imm <= dec_imm;
                    out_v   <= 1'b1;
                end else begin
                    out_v   <= 1'b0;
                end
            end else if (accept) begin
                skid_b   <= dec_b;
                skid_imm <= dec_imm;
                skid_v   <= 1'b1;
            end

            if (accept && dec_b.illegal && illegal_cnt != '1)
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    assign in_ready  = !skid_v;
    assign out_valid = out_v;
    assign alu_op    = ALU_OP_W'(out_b.alu_op);
    assign rs1       = out_b.rs1;
    assign rs2       = out_b.rs2;
    assign rd        = out_b.rd;
    assign imm       = out_imm;
    assign use_imm   = out_b.use_imm;
    assign illegal   = out_b.illegal;

endmodule

// File: tb/tb_cayde_decode_stage.sv
// Bench for cayde_decode_stage: an RV64+M instance and an RV32/no-M/2-bit-counter
// instance share stimulus and are checked against a queue-based reference model.
module tb_cayde_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr_in;

    always #5 clk = ~clk;

    logic        a_in_ready, a_out_valid, a_use_imm, a_illegal;
    logic [6:0]  a_alu_op;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [63:0] a_imm;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid, b_use_imm, b_illegal;
    logic [6:0]  b_alu_op;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [31:0] b_imm;
    logic [1:0]  b_cnt;

    cayde_decode_stage #(.XLEN(64), .EN_MEXT(1'b1), .ALU_OP_W(7), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .instr_in(instr_in), .out_valid(a_out_valid), .out_ready(out_ready),
        .alu_op(a_alu_op), .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd), .imm(a_imm),
        .use_imm(a_use_imm), .illegal(a_illegal), .illegal_cnt(a_cnt)
    );

    cayde_decode_stage #(.XLEN(32), .EN_MEXT(1'b0), .ALU_OP_W(7), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .instr_in(instr_in), .out_valid(b_out_valid), .out_ready(out_ready),
        .alu_op(b_alu_op), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .imm(b_imm),
        .use_imm(b_use_imm), .illegal(b_illegal), .illegal_cnt(b_cnt)
    );

    typedef struct {
        int          op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        bit          use_imm;
        bit          ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        int          a_op;
        logic [4:0]  a_rd;
        logic [63:0] a_imm;
        bit          a_use;
        bit          a_ill;
        bit          b_ill;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cnt_a, cnt_b;
    int   checks, errors;

    function automatic exp_t ref_decode(logic [31:0] w, int xlen, bit mext);
        exp_t       e;
        int         r_ops[8];
        logic [6:0] f7;
        logic [2:0] f3;
        int         shamt;
        bit         hi_zero, hi_sra;
        // ADD SLL SLT SLTU XOR SRL OR AND indexed by funct3
        r_ops   = '{0, 5, 6, 7, 2, 8, 4, 3};
        f7      = w[31:25];
        f3      = w[14:12];
        shamt   = (xlen == 64) ? int'(w[25:20]) : int'(w[24:20]);
        hi_zero = (xlen == 64) ? (w[31:26] == 6'b0) : (w[31:25] == 7'b0);
        hi_sra  = (xlen == 64) ? (w[31:26] == 6'b010000) : (w[31:25] == 7'b0100000);
        e.op = 0; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        e.imm = '0; e.use_imm = 0; e.ill = 0;
        if (w[6:0] == 7'h33) begin
            if (f7 == 7'b0000000)                      e.op = r_ops[f3];
            else if (f7 == 7'b0100000 && f3 == 3'd0)   e.op = 1;
            else if (f7 == 7'b0100000 && f3 == 3'd5)   e.op = 9;
            else if (f7 == 7'b0000001 && mext)         e.op = 10 + int'(f3);
            else                                       e.ill = 1;
        end else if (w[6:0] == 7'h13) begin
            e.use_imm = 1;
            e.rs2 = 0;
            if (f3 == 3'd1) begin
                e.op = 5; e.imm = 64'(shamt); e.ill = !hi_zero;
            end else if (f3 == 3'd5) begin
                e.imm = 64'(shamt);
                if (hi_zero)     e.op = 8;
                else if (hi_sra) e.op = 9;
                else             e.ill = 1;
            end else begin
                e.op  = r_ops[f3];
                e.imm = {{52{w[31]}}, w[31:20]};
            end
        end else begin
            e.ill = 1;
        end
        if (e.ill) begin
            e.op = 0; e.rd = 0; e.use_imm = 0; e.imm = '0;
        end
        if (xlen == 32) e.imm = e.imm & 64'hFFFF_FFFF;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        chk("a_in_ready",  64'(a_in_ready),  64'(qa.size() < 2));
        chk("b_in_ready",  64'(b_in_ready),  64'(qb.size() < 2));
        chk("a_out_valid", 64'(a_out_valid), 64'(qa.size() > 0));
        chk("b_out_valid", 64'(b_out_valid), 64'(qb.size() > 0));
        chk("a_cnt", 64'(a_cnt), 64'(cnt_a));
        chk("b_cnt", 64'(b_cnt), 64'(cnt_b));
        if (qa.size() > 0) begin
            e = qa[0];
            chk("a_alu_op",  64'(a_alu_op),  64'(e.op));
            chk("a_rs1",     64'(a_rs1),     64'(e.rs1));
            chk("a_rd",      64'(a_rd),      64'(e.rd));
            chk("a_imm",     a_imm,          e.imm);
            chk("a_use_imm", 64'(a_use_imm), 64'(e.use_imm));
            chk("a_illegal", 64'(a_illegal), 64'(e.ill));
            if (!e.ill) chk("a_rs2", 64'(a_rs2), 64'(e.rs2));
        end
        if (qb.size() > 0) begin
            e = qb[0];
            chk("b_alu_op",  64'(b_alu_op),  64'(e.op));
            chk("b_rs1",     64'(b_rs1),     64'(e.rs1));
            chk("b_rd",      64'(b_rd),      64'(e.rd));
            chk("b_imm",     64'(b_imm),     e.imm);
            chk("b_use_imm", 64'(b_use_imm), 64'(e.use_imm));
            chk("b_illegal", 64'(b_illegal), 64'(e.ill));
            if (!e.ill) chk("b_rs2", 64'(b_rs2), 64'(e.rs2));
        end
    endtask

    // One clock: drive at the falling edge, check, then advance the model.
    task automatic step(input bit v, input logic [31:0] w, input bit ordy, output bit acc);
        exp_t ea, eb;
        bit   pop;
        in_valid  = v;
        instr_in  = w;
        out_ready = ordy;
        #1;
        check_outputs();
        acc = v && (qa.size() < 2);
        pop = ordy && (qa.size() > 0);
        @(posedge clk);
        if (pop) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
        end
        if (acc) begin
            ea = ref_decode(w, 64, 1'b1);
            eb = ref_decode(w, 32, 1'b0);
            qa.push_back(ea);
            qb.push_back(eb);
            if (ea.ill && cnt_a < 65535) cnt_a++;
            if (eb.ill && cnt_b < 3)     cnt_b++;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [6:0]  f7s[4];
        f7s = '{7'b0000000, 7'b0100000, 7'b0000001, 7'b0000000};
        w = $urandom;
        case ($urandom_range(0, 3))
            0: begin
                w[6:0]   = 7'h33;
                w[31:25] = ($urandom_range(0, 4) == 4) ? 7'($urandom) : f7s[$urandom_range(0, 3)];
            end
            1: begin
                w[6:0] = 7'h13;
                if ($urandom_range(0, 1) == 1) w[12] = 1'b1;
                if ($urandom_range(0, 2) != 0) w[31:26] = $urandom_range(0, 1) ? 6'b010000 : 6'b0;
            end
            2: w[6:0] = 7'h13;
            default: ;
        endcase
        return w;
    endfunction

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        chk("rst_a_in_ready",  64'(a_in_ready),  64'd1);
        chk("rst_a_cnt",       64'(a_cnt),       64'd0);
        chk("rst_b_cnt",       64'(b_cnt),       64'd0);
        qa.delete();
        qb.delete();
        cnt_a = 0;
        cnt_b = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t        tab[7];
    vec_t        v;
    logic [31:0] pend;
    bit          acc;

    initial begin
        checks = 0; errors = 0; cnt_a = 0; cnt_b = 0;
        in_valid = 1'b0; out_ready = 1'b0; instr_in = '0;
        tab[0] = '{32'h002081B3, 0,  5'd3, 64'd0,                  1'b0, 1'b0, 1'b0};
        tab[1] = '{32'h407302B3, 1,  5'd5, 64'd0,                  1'b0, 1'b0, 1'b0};
        tab[2] = '{32'h40315113, 9,  5'd2, 64'd3,                  1'b1, 1'b0, 1'b0};
        tab[3] = '{32'hFFF00093, 0,  5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        tab[4] = '{32'h023100B3, 10, 5'd1, 64'd0,                  1'b0, 1'b0, 1'b1};
        tab[5] = '{32'h02109093, 5,  5'd1, 64'd33,                 1'b1, 1'b0, 1'b1};
        tab[6] = '{32'h00000FFF, 0,  5'd0, 64'd0,                  1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        @(negedge clk);
        apply_reset();
        chk("rst_a_alu_op", 64'(a_alu_op), 64'd0);
        chk("rst_a_rd",     64'(a_rd),     64'd0);
        chk("rst_a_rs1",    64'(a_rs1),    64'd0);
        chk("rst_a_imm",    a_imm,         64'd0);
        @(negedge clk);

        // Back-to-back directed vectors at full throughput.
        foreach (tab[i]) begin
            v = tab[i];
            step(1'b1, v.instr, 1'b1, acc);
            chk("tab_accept",   64'(acc),         64'd1);
            chk("tab_a_valid",  64'(a_out_valid), 64'd1);
            chk("tab_a_alu_op", 64'(a_alu_op),    64'(v.a_op));
            chk("tab_a_rd",     64'(a_rd),        64'(v.a_rd));
            chk("tab_a_imm",    a_imm,            v.a_imm);
            chk("tab_a_use",    64'(a_use_imm),   64'(v.a_use));
            chk("tab_a_ill",    64'(a_illegal),   64'(v.a_ill));
            chk("tab_b_ill",    64'(b_illegal),   64'(v.b_ill));
        end
        step(1'b0, '0, 1'b1, acc);
        chk("tab_a_cnt", 64'(a_cnt), 64'd1);
        chk("tab_b_cnt_sat", 64'(b_cnt), 64'd3);

        // Stall with out_ready low: two accepted, third held off.
        step(1'b1, 32'h002081B3, 1'b0, acc);
        step(1'b1, 32'h407302B3, 1'b0, acc);
        chk("stall_in_ready", 64'(a_in_ready), 64'd0);
        chk("stall_hold_rd1", 64'(a_rd), 64'd3);
        step(1'b1, 32'hFFF00093, 1'b0, acc);
        chk("stall_third_rejected", 64'(acc), 64'd0);
        step(1'b1, 32'hFFF00093, 1'b0, acc);
        chk("stall_hold_rd2", 64'(a_rd), 64'd3);
        step(1'b1, 32'hFFF00093, 1'b1, acc);
        chk("drain_rd_second", 64'(a_rd), 64'd5);
        chk("drain_in_ready", 64'(a_in_ready), 64'd1);
        step(1'b1, 32'hFFF00093, 1'b1, acc);
        chk("drain_third_accepted", 64'(acc), 64'd1);
        chk("drain_rd_third", 64'(a_rd), 64'd1);
        step(1'b0, '0, 1'b1, acc);

        // Reset with both entries full, one of them illegal.
        step(1'b1, 32'h00000FFF, 1'b0, acc);
        step(1'b1, 32'h407302B3, 1'b0, acc);
        chk("prefill_full", 64'(a_in_ready), 64'd0);
        apply_reset();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, acc);

        // Randomised traffic against the reference model.
        pend = gen_instr();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, pend, $urandom_range(0, 2) != 0, acc);
            if (acc) pend = gen_instr();
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
